// File: rtl/bounce_generator.sv
// bounce_generator: mechanical-switch emulator that drives a bouncy signal into a debouncer.
//
// On an accepted trigger, out jumps to the requested level and then toggles 2*BOUNCES times,
// each segment lasting a programmable number of cycles, before settling at the target level
// for SETTLE_CYC cycles. A one-cycle done pulse marks the end of the transition.
//
// Optional feature macro: BOUNCE_GEN_RANDOM_EN
//   defined   - segment lengths are 1 + lfsr[LEN_W-1:0] from a 16-bit Fibonacci LFSR
//   undefined - no LFSR; every segment lasts exactly 2^LEN_W cycles (SEED unused)
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   enable   in   when low, all state (including LFSR and out) is frozen
//   trigger  in   one-cycle request to move out to level
//   level    in   target level, sampled with trigger
//   out      out  bouncy switch signal
//   busy     out  high while a transition is in progress
//   done     out  one-cycle pulse when a transition completes

module bounce_generator #(
    parameter int          BOUNCES    = 3,
    parameter int          LEN_W      = 4,
    parameter int          SETTLE_CYC = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    input  logic trigger,
    input  logic level,
    output logic out,
    output logic busy,
    output logic done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BOUNCE = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam int STL_W = $clog2(SETTLE_CYC + 1);

    localparam logic [8:0]       TOG_INIT = 9'(2 * BOUNCES);
    localparam logic [STL_W-1:0] STL_INIT = STL_W'(SETTLE_CYC);
    localparam logic [STL_W-1:0] STL_ONE  = STL_W'(1);
    localparam logic [LEN_W:0]   SEG_ONE  = (LEN_W + 1)'(1);

    // Elaboration-time parameter sanity checks.
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("bounce_generator: SEED must be nonzero");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("bounce_generator: SETTLE_CYC must be at least 1");
    end

    logic [1:0]       state;
    logic             tgt;
    logic [LEN_W:0]   seg;
    logic [8:0]       tog;
    logic [STL_W-1:0] stl;

    logic             accept;
    logic             seg_load;
    logic [LEN_W:0]   seg_new;

    // A trigger is only meaningful when it actually changes the line.
    assign accept   = trigger && (level != out);
    assign seg_load = ((state == S_IDLE) && accept) ||
                      ((state == S_BOUNCE) && (seg == SEG_ONE) && (tog != 9'd0));

`ifdef BOUNCE_GEN_RANDOM_EN
    logic [15:0] lfsr;
    logic        fb;

    assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign seg_new = (LEN_W + 1)'(lfsr[LEN_W-1:0]) + SEG_ONE;

    // The LFSR steps only when a segment length is consumed, so the length sequence
    // is independent of pauses and idle time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr <= SEED;
        end else if (enable && seg_load) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end
`else
    assign seg_new = {1'b1, {LEN_W{1'b0}}};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            tgt   <= 1'b0;
            seg   <= '0;
            tog   <= '0;
            stl   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // done is a strict one-cycle pulse, even if enable drops right after it.
            done <= 1'b0;
            if (enable) begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            tgt   <= level;
                            out   <= level;
                            tog   <= TOG_INIT;
                            seg   <= seg_new;
                            busy  <= 1'b1;
                            state <= S_BOUNCE;
                        end
                    end
                    S_BOUNCE: begin
                        if (seg == SEG_ONE) begin
                            if (tog != 9'd0) begin
                                out <= ~out;
                                tog <= tog - 9'd1;
                                seg <= seg_new;
                            end else begin
                                // Even toggle count leaves out already at tgt.
                                seg   <= '0;
                                stl   <= STL_INIT;
                                state <= S_SETTLE;
                            end
                        end else begin
                            seg <= seg - SEG_ONE;
                        end
                    end
                    S_SETTLE: begin
                        out <= tgt;
                        if (stl == STL_ONE) begin
                            stl   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            stl <= stl - STL_ONE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: directed bench for bounce_generator.
// Instance A: multi-bounce burst; instance B: BOUNCES=0 (single clean edge).
// Expected segment lengths are hand-derived for each build of BOUNCE_GEN_RANDOM_EN.

module tb_bounce_generator;

`ifdef BOUNCE_GEN_RANDOM_EN
    localparam int A_BOUNCES = 1;
    localparam int A_LEN_W   = 4;
    localparam int A_SETTLE  = 8;
    localparam int A_NSEG    = 3;
`else
    localparam int A_BOUNCES = 2;
    localparam int A_LEN_W   = 2;
    localparam int A_SETTLE  = 3;
    localparam int A_NSEG    = 5;
`endif
    localparam int B_SETTLE = 3;

    logic CLK = 1'b0;
    logic RST;
    logic enable;
    logic trig_a, level_a, trig_b, level_b;
    logic out_a, busy_a, done_a;
    logic out_b, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    bounce_generator #(
        .BOUNCES   (A_BOUNCES),
        .LEN_W     (A_LEN_W),
        .SETTLE_CYC(A_SETTLE),
        .SEED      (16'hACE1)
    ) u_dut_a (
        .CLK    (CLK),
        .RST    (RST),
        .enable (enable),
        .trigger(trig_a),
        .level  (level_a),
        .out    (out_a),
        .busy   (busy_a),
        .done   (done_a)
    );

    bounce_generator #(
        .BOUNCES   (0),
        .LEN_W     (2),
        .SETTLE_CYC(B_SETTLE),
        .SEED      (16'hACE1)
    ) u_dut_b (
        .CLK    (CLK),
        .RST    (RST),
        .enable (enable),
        .trigger(trig_b),
        .level  (level_b),
        .out    (out_b),
        .busy   (busy_b),
        .done   (done_b)
    );

    // Hand-computed segment lengths. Random build: seed 0xACE1 -> 0x59C3 -> 0xB387,
    // low nibbles 1,3,7 give 2,4,8 (LEN_W=4) and low two bits 1 gives 2 (LEN_W=2).
    function automatic int seg_len(input bit sel, input int i);
`ifdef BOUNCE_GEN_RANDOM_EN
        if (sel) return 2;
        if (i == 0) return 2;
        if (i == 1) return 4;
        return 8;
`else
        if (sel || i >= 0) return 4;
        return 4;
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_trig(input bit sel, input logic t, input logic l);
        if (sel) begin
            trig_b  = t;
            level_b = l;
        end else begin
            trig_a  = t;
            level_a = l;
        end
    endtask

    task automatic chk_outs(input bit sel, input string tag, input logic e_out,
                            input logic e_busy, input logic e_done);
        chk({tag, ".out"},  sel ? out_b  : out_a,  e_out);
        chk({tag, ".busy"}, sel ? busy_b : busy_a, e_busy);
        chk({tag, ".done"}, sel ? done_b : done_a, e_done);
    endtask

    // Trigger one transition and check every cycle through done and one cycle after.
    // pause_at: active cycle at which enable is held low for pause_len edges (-1: none).
    // extra_at: wall-cycle index at which a conflicting trigger is injected (-1: none).
    task automatic run(input bit sel, input logic lvl, input int pause_at, input int pause_len,
                       input int extra_at, input string tag);
        int nseg, settle, sum, act, paused, idx, acc;
        logic e_out, e_busy, e_done;
        nseg   = sel ? 1 : A_NSEG;
        settle = sel ? B_SETTLE : A_SETTLE;
        sum    = 0;
        for (int i = 0; i < nseg; i++) sum += seg_len(sel, i);
        @(negedge CLK);
        set_trig(sel, 1'b1, lvl);
        @(negedge CLK);
        set_trig(sel, 1'b0, lvl);
        act    = 1;
        paused = 0;
        for (int w = 0; w < 300 && act <= sum + settle + 1; w++) begin
            if (act <= sum) begin
                acc = 0;
                idx = 0;
                while (act > acc + seg_len(sel, idx)) begin
                    acc += seg_len(sel, idx);
                    idx++;
                end
                e_out  = lvl ^ idx[0];
                e_busy = 1'b1;
                e_done = 1'b0;
            end else if (act <= sum + settle) begin
                e_out  = lvl;
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_out  = lvl;
                e_busy = 1'b0;
                e_done = 1'b1;
            end
            chk_outs(sel, $sformatf("%s@%0d", tag, act), e_out, e_busy, e_done);
            if (act == pause_at && paused < pause_len) begin
                enable = 1'b0;
                paused++;
            end else begin
                enable = 1'b1;
                act++;
            end
            set_trig(sel, (w == extra_at), (w == extra_at) ? ~lvl : lvl);
            @(negedge CLK);
        end
        set_trig(sel, 1'b0, lvl);
        chk(.tag({tag, ".bounded"}), .obs(act > sum + settle + 1), .exp(1'b1));
        chk_outs(sel, {tag, ".after"}, lvl, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST     = 1'b1;
        enable  = 1'b1;
        trig_a  = 1'b0;
        level_a = 1'b0;
        trig_b  = 1'b0;
        level_b = 1'b0;
        repeat (2) @(negedge CLK);
        chk_outs(1'b0, "rst_a", 1'b0, 1'b0, 1'b0);
        chk_outs(1'b1, "rst_b", 1'b0, 1'b0, 1'b0);
        RST = 1'b0;

        // Basic rising transition.
        run(1'b0, 1'b1, -1, 0, -1, "rise");

        // Trigger with level equal to out is ignored.
        @(negedge CLK);
        trig_a  = 1'b1;
        level_a = 1'b1;
        @(negedge CLK);
        trig_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_outs(1'b0, $sformatf("same_lvl%0d", i), 1'b1, 1'b0, 1'b0);
            @(negedge CLK);
        end

        // Second trigger while busy has no effect.
        do_reset();
        run(1'b0, 1'b1, -1, 0, 2, "busy_trig");

        // Enable low for 5 cycles mid-burst delays everything by 5.
        do_reset();
        run(1'b0, 1'b1, 4, 5, -1, "pause");

        // Reset mid-burst, then the same scenario must reproduce exactly.
        do_reset();
        @(negedge CLK);
        trig_a  = 1'b1;
        level_a = 1'b1;
        @(negedge CLK);
        trig_a = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_outs(1'b0, "mid_rst", 1'b0, 1'b0, 1'b0);
        run(1'b0, 1'b1, -1, 0, -1, "rerun");

`ifndef BOUNCE_GEN_RANDOM_EN
        // Falling transition: burst starts at 0 and alternates.
        run(1'b0, 1'b0, -1, 0, -1, "fall");
`endif

        // BOUNCES=0: single clean edge then settle.
        do_reset();
        run(1'b1, 1'b1, -1, 0, -1, "zero_b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bounce_generator.md
# bounce_generator

Synthesizable mechanical-switch emulator that produces the bouncy signal a `Debouncer` consumes. On command, it drives a clean level transition corrupted by a programmable burst of pseudo-random glitches, then holds the settled level. It sits on the FPGA ahead of `Debouncer.in`, so the debouncer can be exercised in hardware without a physical button. A `done` pulse tells the controlling logic when the emulated switch has settled.

## Interface
Parameters:
- `BOUNCES`, 3: glitch pairs per transition; 0 gives a clean edge. Range 0–255.
- `LEN_W`, 4: segment-length width; a segment lasts 1..2^LEN_W cycles.
- `SETTLE_CYC`, 16: cycles the settled level is held, with `busy` high, before `done`. Must be ≥1.
- `SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `enable` in 1: when low, state, counters, LFSR and `out` are frozen.
- `trigger` in 1: one-cycle request to move `out` to `level`.
- `level` in 1: target level, sampled with `trigger`.
- `out` out 1: bouncy switch signal. Drives `Debouncer.in`.
- `busy` out 1: high while a transition is in progress.
- `done` out 1: one-cycle pulse when a transition completes.

## Operation
- The FSM has three states: IDLE, BOUNCE and SETTLE. Registers: `tgt`, `seg` (LEN_W+1 bits), `tog` (9 bits), `stl`, and a 16-bit `lfsr`.
- LFSR is Fibonacci x^16+x^14+x^13+x^11+1.
  - Feedback: fb = l[15]^l[13]^l[12]^l[10].
  - Next value: {l[14:0], fb}.
  - It advances only on a segment load, never on other cycles.
- Segment load: `seg` <= 1 + lfsr[LEN_W-1:0], using the current LFSR value. The LFSR advances on the same edge.
- IDLE:
  - Accepts when `enable && trigger && level != out`.
  - On accept: `tgt`<=`level`, `out`<=`level`, `tog`<=2*BOUNCES, load a segment, go to BOUNCE.
  - A trigger with `level == out` is ignored: no busy, no done.
- BOUNCE:
  - While enabled, `seg` decrements each cycle.
  - On the expiry cycle (`seg==1`) with `tog!=0`: `out`<=~`out`, `tog`--, load a segment.
  - On the expiry cycle with `tog==0`: go to SETTLE and set `stl`<=SETTLE_CYC. `out` already equals `tgt` because the toggle count is even.
- SETTLE:
  - `out` holds at `tgt`; `stl` decrements.
  - On the expiry cycle (`stl==1`) go to IDLE, with `done`<=1 for one cycle.
- `trigger` while `busy` is ignored and is not queued.
- `enable` low mid-operation pauses everything. The sequence resumes unchanged when `enable` returns, and `done` cannot pulse while `enable` is low.
- `RST` at any time, including mid-burst:
  - State = IDLE, `out`=0, `busy`=0, `done`=0, `lfsr`=SEED, all counters cleared.
  - Reset takes priority over `trigger`.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Accept at edge t: `out`=`level` and `busy`=1 from cycle t+1.
- Each segment holds `out` constant for exactly its length L in cycles (with `enable` high). A burst contains 2*BOUNCES+1 segments.
- After the last segment, `out` holds `tgt` for SETTLE_CYC cycles with `busy`=1.
- On the next cycle, `busy`=0 and `done`=1, and a new trigger can be accepted in that same cycle.
- Total latency from trigger to done = 1 + ΣL + SETTLE_CYC cycles.

## Configuration
- `BOUNCE_GEN_RANDOM_EN` defined:
  - Segment lengths come from the LFSR as described above.
- `BOUNCE_GEN_RANDOM_EN` undefined:
  - No LFSR is built, and `SEED` is unused.
  - Every segment lasts exactly 2^LEN_W cycles, so the burst pattern is fully periodic.

## Test plan
- Random length, clean reset. Setup: defaults except BOUNCES=1 and SETTLE_CYC=8, random on. After reset, trigger=1, level=1 at cycle 0. Required response:
  - `out`=1 on cycles 1–2 (L=2), 0 on cycles 3–6 (L=4), 1 on cycles 7–14 (L=8).
  - `busy`=1 on cycles 1–22.
  - `done`=1 on cycle 23 only.
- Random off. Setup: BOUNCES=2, LEN_W=2, SETTLE_CYC=3. Trigger level=1 at cycle 0. Required response:
  - `out` = 1,0,1,0,1 in 4-cycle segments, spanning cycles 1–20.
  - `busy` falls and `done` pulses at cycle 24.
- Ignored triggers:
  - Trigger with `level==out` → no `busy`, no `done`, `out` unchanged.
  - A second trigger while `busy` → no effect on the running sequence.
- Pause. Drop `enable` for 5 cycles in mid-BOUNCE → every `out` edge and `done` are delayed by exactly 5 cycles.
- Reset mid-burst. Assert `RST` during BOUNCE → next cycle `out`=0, `busy`=0, `done`=0. Re-running the random-length scenario reproduces identical waveforms.
- BOUNCES=0 → single clean edge, then SETTLE_CYC cycles, then `done`.
